// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control, preset and display bundle for the BCD mm:ss
// countdown timer. The BEEP wire exists only when COUNTDOWN_BEEP_EN is defined.
// master = controller/driver side, slave = timer side.
interface countdown_timer_if;
  logic       EN;
  logic       LD;
  logic       START;
  logic       PAUSE;
  logic [3:0] PRE_MT;
  logic [3:0] PRE_MU;
  logic [3:0] PRE_ST;
  logic [3:0] PRE_SU;
  logic [3:0] QMT;
  logic [3:0] QMU;
  logic [3:0] QST;
  logic [3:0] QSU;
  logic       RUN;
  logic       DONE;
  logic       ZERO;
`ifdef COUNTDOWN_BEEP_EN
  logic       BEEP;
`endif

  modport master (
    output EN, LD, START, PAUSE, PRE_MT, PRE_MU, PRE_ST, PRE_SU,
    input  QMT, QMU, QST, QSU, RUN, DONE, ZERO
`ifdef COUNTDOWN_BEEP_EN
    , input BEEP
`endif
  );

  modport slave (
    input  EN, LD, START, PAUSE, PRE_MT, PRE_MU, PRE_ST, PRE_SU,
    output QMT, QMU, QST, QSU, RUN, DONE, ZERO
`ifdef COUNTDOWN_BEEP_EN
    , output BEEP
`endif
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: BCD mm:ss down-counter. Loads a saturated BCD preset,
// decrements one second per EN tick while running, pulses DONE for one cycle
// on reaching 00:00 and then holds until a new load or reset.
// Optional feature macro: COUNTDOWN_BEEP_EN adds the BEEP alarm output and its
// EN-tick counter; without it the timer behaves identically minus BEEP.
module countdown_timer #(
  parameter int MT_MAX     = 5,
  parameter int BEEP_TICKS = 10
) (
  input logic               CP,
  input logic               nCR,
  countdown_timer_if.slave  bus
);

  // Elaboration-time sanity on the configuration.
  if (MT_MAX < 0 || MT_MAX > 9) begin : g_bad_mt_max
    $error("countdown_timer: MT_MAX must be a BCD digit");
  end
  if (BEEP_TICKS < 1) begin : g_bad_beep_ticks
    $error("countdown_timer: BEEP_TICKS must be at least 1");
  end

  localparam logic [3:0] MT_LIM = 4'(MT_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t     state_q;
  logic [3:0] mt_q, mu_q, st_q, su_q;
  logic       run_q;
  logic       done_q;

  logic [3:0] pre_mt_sat, pre_mu_sat, pre_st_sat, pre_su_sat;
  logic [3:0] mt_dec, mu_dec, st_dec, su_dec;
  logic       count_zero;
  logic       dec_zero;
  logic       dec_now;
  logic       expire_now;

  // Clamp preset digits into the legal range of each position.
  always_comb begin
    pre_mt_sat = (bus.PRE_MT > MT_LIM) ? MT_LIM : bus.PRE_MT;
    pre_mu_sat = (bus.PRE_MU > 4'd9)   ? 4'd9   : bus.PRE_MU;
    pre_st_sat = (bus.PRE_ST > 4'd5)   ? 4'd5   : bus.PRE_ST;
    pre_su_sat = (bus.PRE_SU > 4'd9)   ? 4'd9   : bus.PRE_SU;
  end

  // One-second decrement with ripple borrow through the four BCD digits.
  // Only used while running, where the count is never 00:00.
  always_comb begin
    mt_dec = mt_q;
    mu_dec = mu_q;
    st_dec = st_q;
    su_dec = su_q;
    if (su_q != 4'd0) begin
      su_dec = su_q - 4'd1;
    end else begin
      su_dec = 4'd9;
      if (st_q != 4'd0) begin
        st_dec = st_q - 4'd1;
      end else begin
        st_dec = 4'd5;
        if (mu_q != 4'd0) begin
          mu_dec = mu_q - 4'd1;
        end else begin
          mu_dec = 4'd9;
          mt_dec = mt_q - 4'd1;
        end
      end
    end
  end

  assign count_zero = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd0);
  assign dec_zero   = (mt_dec == 4'd0) && (mu_dec == 4'd0) && (st_dec == 4'd0) && (su_dec == 4'd0);

  // A tick only counts in RUN when no higher-priority control is present.
  assign dec_now    = (state_q == S_RUN) && !bus.LD && !bus.PAUSE && !bus.START && bus.EN;
  assign expire_now = dec_now && dec_zero;

  // Timer FSM: state, digit registers and the registered RUN/DONE outputs.
  always_ff @(posedge CP) begin
    if (!nCR) begin
      state_q <= S_IDLE;
      mt_q    <= 4'd0;
      mu_q    <= 4'd0;
      st_q    <= 4'd0;
      su_q    <= 4'd0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.LD) begin
        mt_q    <= pre_mt_sat;
        mu_q    <= pre_mu_sat;
        st_q    <= pre_st_sat;
        su_q    <= pre_su_sat;
        state_q <= S_IDLE;
        run_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.START && !count_zero) begin
              state_q <= S_RUN;
              run_q   <= 1'b1;
            end
          end
          S_RUN: begin
            if (bus.PAUSE) begin
              state_q <= S_PAUSE;
              run_q   <= 1'b0;
            end else if (dec_now) begin
              mt_q <= mt_dec;
              mu_q <= mu_dec;
              st_q <= st_dec;
              su_q <= su_dec;
              if (dec_zero) begin
                state_q <= S_EXPIRED;
                run_q   <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          S_PAUSE: begin
            if (bus.START) begin
              state_q <= S_RUN;
              run_q   <= 1'b1;
            end
          end
          default: begin
            // EXPIRED holds 00:00 until a load or reset.
          end
        endcase
      end
    end
  end

`ifdef COUNTDOWN_BEEP_EN
  localparam int BCW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
  localparam logic [BCW-1:0] BEEP_LAST = BCW'(BEEP_TICKS - 1);

  logic           beep_q;
  logic [BCW-1:0] beep_cnt_q;

  // Alarm level: rises on the expiry edge, falls after BEEP_TICKS further ticks.
  always_ff @(posedge CP) begin
    if (!nCR || bus.LD) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else if (expire_now) begin
      beep_q     <= 1'b1;
      beep_cnt_q <= '0;
    end else if (beep_q && bus.EN) begin
      if (beep_cnt_q == BEEP_LAST) begin
        beep_q <= 1'b0;
      end else begin
        beep_cnt_q <= beep_cnt_q + 1'b1;
      end
    end
  end

  assign bus.BEEP = beep_q;
`else
  logic unused_expire;
  assign unused_expire = expire_now;
`endif

  assign bus.QMT  = mt_q;
  assign bus.QMU  = mu_q;
  assign bus.QST  = st_q;
  assign bus.QSU  = su_q;
  assign bus.RUN  = run_q;
  assign bus.DONE = done_q;
  assign bus.ZERO = count_zero;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer. The driver applies one set of inputs
// per cycle on the falling edge, advances a seconds-based reference model and
// queues the expected outputs; a monitor pops and compares after each rising edge.
module tb_countdown_timer;
  localparam int MT_MAX     = 5;
  localparam int BEEP_TICKS = 10;

  logic CP;
  logic nCR;
  countdown_timer_if bus ();

  countdown_timer #(.MT_MAX(MT_MAX), .BEEP_TICKS(BEEP_TICKS)) dut (
    .CP  (CP),
    .nCR (nCR),
    .bus (bus)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  typedef struct {
    logic [3:0] mt, mu, st, su;
    logic       run, done, zero, beep;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: count kept as plain seconds.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_EXPIRED} mstate_t;
  mstate_t m_state    = M_IDLE;
  int      m_total    = 0;
  bit      m_done     = 0;
  int      m_beep_left = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.mt   = 4'(m_total / 600);
    e.mu   = 4'((m_total / 60) % 10);
    e.st   = 4'((m_total % 60) / 10);
    e.su   = 4'(m_total % 10);
    e.run  = (m_state == M_RUN);
    e.done = m_done;
    e.zero = (m_total == 0);
`ifdef COUNTDOWN_BEEP_EN
    e.beep = (m_beep_left > 0);
`else
    e.beep = 1'b0;
`endif
    return e;
  endfunction

  task automatic model_edge(input bit ncr, ld, start, pause, en,
                            input int pmt, pmu, pst, psu);
    m_done = 0;
    if (!ncr) begin
      m_state = M_IDLE; m_total = 0; m_beep_left = 0;
    end else if (ld) begin
      m_total = imin(pmt, MT_MAX) * 600 + imin(pmu, 9) * 60 + imin(pst, 5) * 10 + imin(psu, 9);
      m_state = M_IDLE; m_beep_left = 0;
    end else begin
      if (en && m_beep_left > 0) m_beep_left--;
      case (m_state)
        M_IDLE:  if (start && m_total != 0) m_state = M_RUN;
        M_RUN: begin
          if (pause) m_state = M_PAUSE;
          else if (!start && en) begin
            m_total--;
            if (m_total == 0) begin
              m_state = M_EXPIRED; m_done = 1; m_beep_left = BEEP_TICKS;
            end
          end
        end
        M_PAUSE: if (start) m_state = M_RUN;
        default: ;
      endcase
    end
  endtask

  // One cycle of stimulus: drive on the falling edge and queue the expectation.
  task automatic step(input bit ncr, ld, start, pause, en,
                      input int pmt = 0, pmu = 0, pst = 0, psu = 0);
    @(negedge CP);
    nCR       = ncr;
    bus.LD    = ld;
    bus.START = start;
    bus.PAUSE = pause;
    bus.EN    = en;
    bus.PRE_MT = 4'(pmt); bus.PRE_MU = 4'(pmu);
    bus.PRE_ST = 4'(pst); bus.PRE_SU = 4'(psu);
    model_edge(ncr, ld, start, pause, en, pmt, pmu, pst, psu);
    sb_q.push_back(model_out());
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask
  task automatic load(input int a, b, c, d);
    step(1, 1, 0, 0, 0, a, b, c, d);
  endtask
  task automatic start();
    step(1, 0, 1, 0, 0);
  endtask
  task automatic pause();
    step(1, 0, 0, 1, 0);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 1);
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    logic got_beep;
    forever begin
      @(posedge CP);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
`ifdef COUNTDOWN_BEEP_EN
        got_beep = bus.BEEP;
`else
        got_beep = 1'b0;
`endif
        checks++;
        if (bus.QMT !== e.mt || bus.QMU !== e.mu || bus.QST !== e.st || bus.QSU !== e.su ||
            bus.RUN !== e.run || bus.DONE !== e.done || bus.ZERO !== e.zero || got_beep !== e.beep) begin
          errors++;
          $display("FAIL outputs @%0t: got %h%h:%h%h run=%b done=%b zero=%b beep=%b, expected %h%h:%h%h run=%b done=%b zero=%b beep=%b",
                   $time, bus.QMT, bus.QMU, bus.QST, bus.QSU, bus.RUN, bus.DONE, bus.ZERO, got_beep,
                   e.mt, e.mu, e.st, e.su, e.run, e.done, e.zero, e.beep);
        end
      end
    end
  end

  initial begin
    nCR = 1'b0; bus.LD = 1'b0; bus.START = 1'b0; bus.PAUSE = 1'b0; bus.EN = 1'b0;
    bus.PRE_MT = '0; bus.PRE_MU = '0; bus.PRE_ST = '0; bus.PRE_SU = '0;

    // Reset state.
    step(0, 0, 0, 0, 0);
    idle_cyc(2);
    $display("txn reset: checks=%0d", checks);

    // 01:00 down to 00:00 over 60 ticks, DONE for one cycle.
    load(0, 1, 0, 0); start(); ticks(60); idle_cyc(3);
    $display("txn 01:00 full run: checks=%0d", checks);

    // Full borrow chain 10:00 -> 09:59; START-coincident EN does not count.
    load(1, 0, 0, 0); step(1, 0, 1, 0, 1); ticks(1); idle_cyc(1);
    $display("txn 10:00 borrow: checks=%0d", checks);

    // 00:05 with pause (EN during pause and with PAUSE ignored).
    load(0, 0, 0, 5); start(); ticks(2); step(1, 0, 0, 1, 1); ticks(3);
    start(); ticks(3); idle_cyc(2);
    $display("txn 00:05 pause/resume: checks=%0d", checks);

    // Saturating preset and START with 00:00 loaded.
    load(15, 15, 15, 15); idle_cyc(1); load(7, 10, 6, 12); idle_cyc(1);
    load(0, 0, 0, 0); start(); idle_cyc(1);
    $display("txn saturate/zero start: checks=%0d", checks);

    // LD coincident with the expiry edge wins; no DONE.
    load(0, 0, 0, 1); start(); step(1, 1, 0, 0, 1, 0, 0, 0, 3); idle_cyc(1);
    // Expired state ignores START/PAUSE/EN.
    start(); ticks(3); idle_cyc(1); start(); pause(); ticks(2);
    $display("txn ld-at-expiry/expired hold: checks=%0d", checks);

    // START+PAUSE together in RUN and in PAUSE.
    load(0, 0, 2, 0); start(); ticks(2); step(1, 0, 1, 1, 0); ticks(2);
    step(1, 0, 1, 1, 1); ticks(2);
    // Reset mid-run.
    step(0, 0, 0, 0, 1); idle_cyc(1); ticks(1);
    $display("txn start+pause/reset mid-run: checks=%0d", checks);

    // Beep window length and LD cutting a beep short.
    load(0, 0, 0, 2); start(); ticks(2); ticks(12); idle_cyc(1);
    load(0, 0, 0, 1); start(); ticks(1); ticks(3); load(0, 0, 0, 4); idle_cyc(1);
    load(0, 0, 0, 1); start(); ticks(1); ticks(2); step(0, 0, 0, 0, 0); idle_cyc(1);
    $display("txn beep: checks=%0d", checks);

    // Randomized operation.
    for (int i = 0; i < 3000; i++) begin
      bit ncr, ld, st, pa, en;
      int pmt, pmu, pst, psu;
      ncr = ($urandom_range(0, 199) != 0);
      ld  = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 7) == 0);
      pa  = ($urandom_range(0, 15) == 0);
      en  = ($urandom_range(0, 1) == 1);
      if (m_state == M_IDLE && st) pa = 0;
      if (m_state == M_RUN && st && !pa) en = 0;
      if ($urandom_range(0, 3) != 0) begin
        pmt = 0; pmu = 0; pst = $urandom_range(0, 1); psu = $urandom_range(0, 15);
      end else begin
        pmt = $urandom_range(0, 15); pmu = $urandom_range(0, 15);
        pst = $urandom_range(0, 15); psu = $urandom_range(0, 15);
      end
      step(ncr, ld, st, pa, en, pmt, pmu, pst, psu);
      if (i % 500 == 499) $display("txn random batch %0d: checks=%0d", i / 500, checks);
    end

    idle_cyc(2);
    @(negedge CP);
    @(negedge CP);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
